// File: rtl/ysyx_24110006_lsu_sb.sv
// Load/store unit with a posted store buffer: loads wait for the buffer to drain,
// stores retire immediately and are written out by an independent drain engine.
`timescale 1ns/1ps
module ysyx_24110006_lsu_sb #(
    parameter int SB_DEPTH = 4,
    parameter int SIDE_W   = 64
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_flush,
    input  logic              i_ren,
    input  logic              i_wen,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wmask,
    input  logic [2:0]        i_read_t,
    input  logic [SIDE_W-1:0] i_side,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_result,
    output logic [SIDE_W-1:0] o_side,
    output logic              o_exception,
    output logic [3:0]        o_mcause,
    output logic              o_store_err,
    output logic              o_sb_empty,
    output logic [31:0]       o_araddr,
    output logic              o_arvalid,
    input  logic              i_arready,
    output logic [3:0]        o_arid,
    output logic [7:0]        o_arlen,
    output logic [2:0]        o_arsize,
    output logic [1:0]        o_arburst,
    input  logic              i_rvalid,
    output logic              o_rready,
    input  logic [31:0]       i_rdata,
    input  logic [1:0]        i_rresp,
    output logic [31:0]       o_awaddr,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [3:0]        o_awid,
    output logic [7:0]        o_awlen,
    output logic [2:0]        o_awsize,
    output logic [1:0]        o_awburst,
    output logic [31:0]       o_wdata,
    output logic [3:0]        o_wstrb,
    output logic              o_wvalid,
    input  logic              i_wready,
    output logic              o_wlast,
    input  logic              i_bvalid,
    output logic              o_bready,
    input  logic [1:0]        i_bresp
);
    localparam int PW = $clog2(SB_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_SBWAIT, S_AR, S_R, S_RESP} state_t;

    state_t            r_state;
    logic              r_valid, r_exc, r_arvalid;
    logic [31:0]       r_result, r_addr;
    logic [3:0]        r_mcause;
    logic [2:0]        r_read_t;
    logic [SIDE_W-1:0] r_side;

    logic [31:0] r_sb_addr [SB_DEPTH];
    logic [31:0] r_sb_data [SB_DEPTH];
    logic [3:0]  r_sb_strb [SB_DEPTH];
    logic [1:0]  r_sb_size [SB_DEPTH];
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [PW:0]   r_count;
    logic          r_dbusy, r_awvalid, r_wvalid, r_store_err;

    logic        w_full, w_push, w_pop, w_accept, w_misalign;
    logic [1:0]  w_ssize, w_size, w_lane;
    logic [31:0] w_wdata_sh, w_rsh, w_ld;
    logic [3:0]  w_wstrb_sh;

    assign w_full     = (r_count == (PW+1)'(SB_DEPTH));
    assign w_pop      = r_dbusy && i_bvalid;
    assign o_ready    = (r_state == S_IDLE) && !(i_valid && i_wen && w_full && !w_pop);
    assign w_accept   = i_valid && o_ready && !i_flush;

    // Store width is implied by the byte strobe, load width by read_t.
    assign w_ssize    = i_wmask[3] ? 2'd2 : (i_wmask[1] ? 2'd1 : 2'd0);
    assign w_size     = i_wen ? w_ssize : i_read_t[1:0];
    assign w_misalign = (i_ren || i_wen) &&
                        ((w_size == 2'd1 && i_addr[0]) || (w_size == 2'd2 && i_addr[1:0] != 2'b00));
    assign w_push     = w_accept && i_wen && !w_misalign;
    assign w_lane     = i_addr[1:0];
    assign w_wdata_sh = i_wdata << {w_lane, 3'b000};
    assign w_wstrb_sh = i_wmask << w_lane;

    assign w_rsh = i_rdata >> {r_addr[1:0], 3'b000};
    always_comb begin
        w_ld = w_rsh;
        case (r_read_t)
            3'b000:  w_ld = {{24{w_rsh[7]}}, w_rsh[7:0]};
            3'b001:  w_ld = {{16{w_rsh[15]}}, w_rsh[15:0]};
            3'b100:  w_ld = {24'd0, w_rsh[7:0]};
            3'b101:  w_ld = {16'd0, w_rsh[15:0]};
            default: w_ld = w_rsh;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_exc     <= 1'b0;
            r_mcause  <= 4'd0;
            r_result  <= 32'd0;
            r_addr    <= 32'd0;
            r_read_t  <= 3'd0;
            r_side    <= '0;
            r_arvalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_side   <= i_side;
                    r_addr   <= i_addr;
                    r_read_t <= i_read_t;
                    r_result <= i_addr;
                    r_exc    <= 1'b0;
                    r_mcause <= 4'd0;
                    if (w_misalign) begin
                        r_exc    <= 1'b1;
                        r_mcause <= i_wen ? 4'd6 : 4'd4;
                        r_valid  <= 1'b1;
                        r_state  <= S_RESP;
                    end else if (i_ren && !i_wen) begin
                        r_state <= S_SBWAIT;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_SBWAIT: if (o_sb_empty) begin
                    r_arvalid <= 1'b1;
                    r_state   <= S_AR;
                end
                S_AR: if (i_arready) begin
                    r_arvalid <= 1'b0;
                    r_state   <= S_R;
                end
                S_R: if (i_rvalid) begin
                    r_result <= w_ld;
                    r_exc    <= (i_rresp != 2'b00);
                    r_mcause <= (i_rresp != 2'b00) ? 4'd5 : 4'd0;
                    r_valid  <= 1'b1;
                    r_state  <= S_RESP;
                end
                S_RESP: if (i_ready) begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Entry payload needs no reset; only pointers and count define validity.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_sb_addr[r_wr_ptr] <= i_addr;
            r_sb_data[r_wr_ptr] <= w_wdata_sh;
            r_sb_strb[r_wr_ptr] <= w_wstrb_sh;
            r_sb_size[r_wr_ptr] <= w_ssize;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_dbusy     <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_store_err <= 1'b0;
        end else begin
            r_store_err <= w_pop && (i_bresp != 2'b00);
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (!r_dbusy && r_count != '0) begin
                r_dbusy   <= 1'b1;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
            end else if (r_dbusy) begin
                if (r_awvalid && i_awready) r_awvalid <= 1'b0;
                if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
                if (i_bvalid)               r_dbusy   <= 1'b0;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_result    = r_result;
    assign o_side      = r_side;
    assign o_exception = r_exc;
    assign o_mcause    = r_mcause;
    assign o_store_err = r_store_err;
    assign o_sb_empty  = (r_count == '0);

    assign o_araddr  = r_addr;
    assign o_arvalid = r_arvalid;
    assign o_arid    = 4'd0;
    assign o_arlen   = 8'd0;
    assign o_arsize  = {1'b0, r_read_t[1:0]};
    assign o_arburst = 2'b00;
    assign o_rready  = i_reset_n;

    assign o_awaddr  = r_sb_addr[r_rd_ptr];
    assign o_awvalid = r_awvalid;
    assign o_awid    = 4'd0;
    assign o_awlen   = 8'd0;
    assign o_awsize  = {1'b0, r_sb_size[r_rd_ptr]};
    assign o_awburst = 2'b00;
    assign o_wdata   = r_sb_data[r_rd_ptr];
    assign o_wstrb   = r_sb_strb[r_rd_ptr];
    assign o_wvalid  = r_wvalid;
    assign o_wlast   = 1'b1;
    assign o_bready  = i_reset_n;
endmodule

// File: tb/tb_ysyx_24110006_lsu_sb.sv
// Bench for the LSU store buffer: vector table plus corner sequences, with
// response and write scoreboards fed at stimulus time.
`timescale 1ns/1ps
module tb_ysyx_24110006_lsu_sb;
    logic i_clock, i_reset_n, i_valid, o_ready, i_flush, i_ren, i_wen;
    logic [31:0] i_addr, i_wdata;
    logic [3:0] i_wmask;
    logic [2:0] i_read_t;
    logic [63:0] i_side, o_side;
    logic o_valid, i_ready, o_exception, o_store_err, o_sb_empty;
    logic [31:0] o_result;
    logic [3:0] o_mcause;
    logic [31:0] o_araddr, o_awaddr, o_wdata, i_rdata;
    logic o_arvalid, i_arready, i_rvalid, o_rready, o_awvalid, i_awready;
    logic o_wvalid, i_wready, o_wlast, i_bvalid, o_bready;
    logic [3:0] o_arid, o_awid, o_wstrb;
    logic [7:0] o_arlen, o_awlen;
    logic [2:0] o_arsize, o_awsize;
    logic [1:0] o_arburst, o_awburst, i_rresp, i_bresp;

    ysyx_24110006_lsu_sb #(.SB_DEPTH(4), .SIDE_W(64)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wmask(i_wmask), .i_read_t(i_read_t), .i_side(i_side), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_side(o_side), .o_exception(o_exception),
        .o_mcause(o_mcause), .o_store_err(o_store_err), .o_sb_empty(o_sb_empty),
        .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready), .o_arid(o_arid),
        .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst), .i_rvalid(i_rvalid),
        .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp), .o_awaddr(o_awaddr),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awid(o_awid), .o_awlen(o_awlen),
        .o_awsize(o_awsize), .o_awburst(o_awburst), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wlast(o_wlast), .i_bvalid(i_bvalid),
        .o_bready(o_bready), .i_bresp(i_bresp)
    );

    typedef struct {
        logic [31:0] res; logic chk_res; logic exc; logic [3:0] mc; logic [63:0] side;
    } exp_t;
    typedef struct {
        logic [31:0] a; logic [31:0] d; logic [3:0] s; logic [2:0] sz;
    } wexp_t;
    typedef struct {
        logic ren; logic wen; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask;
        logic [2:0] rt; logic [31:0] rdata; logic [1:0] rresp;
        logic chk_res; logic [31:0] res; logic exc; logic [3:0] mc;
        logic wr; logic [31:0] wa; logic [31:0] wd; logic [3:0] ws; logic [2:0] wsz;
    } vec_t;

    exp_t  exp_q[$];
    wexp_t wexp_q[$];
    vec_t  vt[16];
    int checks = 0, failures = 0;
    int xfer_cnt = 0, aw_cnt = 0, wr_total = 0, viol = 0, err_hi = 0, err_rise = 0;
    logic err_prev = 1'b0;

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ren, wen, input logic [31:0] addr, wdata,
                                input logic [3:0] mask, input logic [2:0] rt,
                                input logic [31:0] rdata, input logic [1:0] rresp,
                                input logic chk_res, input logic [31:0] res,
                                input logic exc, input logic [3:0] mc, input logic wr,
                                input logic [31:0] wa, wd, input logic [3:0] ws,
                                input logic [2:0] wsz);
        vec_t v;
        v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata; v.mask = mask; v.rt = rt;
        v.rdata = rdata; v.rresp = rresp; v.chk_res = chk_res; v.res = res; v.exc = exc;
        v.mc = mc; v.wr = wr; v.wa = wa; v.wd = wd; v.ws = ws; v.wsz = wsz;
        return v;
    endfunction

    task automatic push_exp(input logic [31:0] res, input logic cr, input logic exc,
                            input logic [3:0] mc, input logic [63:0] side);
        exp_t e;
        e.res = res; e.chk_res = cr; e.exc = exc; e.mc = mc; e.side = side;
        exp_q.push_back(e);
    endtask

    task automatic push_w(input logic [31:0] a, d, input logic [3:0] s, input logic [2:0] sz);
        wexp_t w;
        w.a = a; w.d = d; w.s = s; w.sz = sz;
        wexp_q.push_back(w);
        wr_total++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic ren, wen, input logic [31:0] addr, wdata,
                        input logic [3:0] mask, input logic [2:0] rt, input logic [63:0] side);
        bit got = 0;
        i_valid = 1'b1; i_ren = ren; i_wen = wen; i_addr = addr; i_wdata = wdata;
        i_wmask = mask; i_read_t = rt; i_side = side;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge i_clock);
            got = o_ready && !i_flush;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL send_accept act=timeout exp=o_ready addr=%h", addr);
        end
        @(posedge i_clock); #1;
        i_valid = 1'b0; i_ren = 1'b0; i_wen = 1'b0;
    endtask

    task automatic wait_idle(input bit resp_only);
        bit done = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge i_clock);
            done = (exp_q.size() == 0) &&
                   (resp_only || (wexp_q.size() == 0 && o_sb_empty && !i_bvalid));
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL wait_idle act=timeout exp=drained q=%0d wq=%0d", exp_q.size(), wexp_q.size());
        end
        @(posedge i_clock); #1;
    endtask

    // Response monitor: scoreboard pop on transfer, stability while stalled.
    initial begin
        exp_t e;
        logic stall_prev = 1'b0;
        logic [31:0] p_res = '0;
        logic [63:0] p_side = '0;
        logic p_exc = 1'b0;
        forever begin
            @(negedge i_clock);
            if (stall_prev) begin
                chk("stall_valid", {63'd0, o_valid}, 64'd1);
                chk("stall_result", {32'd0, o_result}, {32'd0, p_res});
                chk("stall_side", o_side, p_side);
                chk("stall_exc", {63'd0, o_exception}, {63'd0, p_exc});
            end
            if (o_valid && i_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_resp act=%h exp=none", o_result);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_res) chk("result", {32'd0, o_result}, {32'd0, e.res});
                    chk("exception", {63'd0, o_exception}, {63'd0, e.exc});
                    chk("mcause", {60'd0, o_mcause}, {60'd0, e.mc});
                    chk("side", o_side, e.side);
                end
            end
            stall_prev = o_valid && !i_ready;
            p_res = o_result; p_side = o_side; p_exc = o_exception;
            if (o_arvalid && !o_sb_empty) viol++;
            if (o_store_err) err_hi++;
            if (o_store_err && !err_prev) err_rise++;
            err_prev = o_store_err;
        end
    end

    // AXI slave: captures aw/w, checks against write scoreboard, returns r/b.
    initial begin
        wexp_t w;
        bit ar_hs, got_aw = 0, got_w = 0;
        logic [31:0] ca = '0, cd = '0;
        logic [3:0] cs = '0;
        logic [2:0] csz = '0;
        i_rvalid = 1'b0; i_bvalid = 1'b0;
        forever begin
            @(negedge i_clock);
            ar_hs = o_arvalid && i_arready;
            if (o_awvalid && i_awready) begin aw_cnt++; got_aw = 1; ca = o_awaddr; csz = o_awsize; end
            if (o_wvalid && i_wready) begin got_w = 1; cd = o_wdata; cs = o_wstrb; end
            @(posedge i_clock); #1;
            i_rvalid = ar_hs && i_reset_n;
            if (i_bvalid) i_bvalid = 1'b0;
            else if (got_aw && got_w) begin
                if (wexp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write act=%h exp=none", ca);
                end else begin
                    w = wexp_q.pop_front();
                    chk("awaddr", {32'd0, ca}, {32'd0, w.a});
                    chk("wdata", {32'd0, cd}, {32'd0, w.d});
                    chk("wstrb", {60'd0, cs}, {60'd0, w.s});
                    chk("awsize", {61'd0, csz}, {61'd0, w.sz});
                end
                i_bvalid = 1'b1;
                got_aw = 0; got_w = 0;
            end
        end
    end

    initial begin
        logic seen;
        bit got;
        int saved;
        i_reset_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ren = 1'b0; i_wen = 1'b0;
        i_addr = '0; i_wdata = '0; i_wmask = '0; i_read_t = '0; i_side = '0;
        i_ready = 1'b1; i_arready = 1'b1; i_awready = 1'b1; i_wready = 1'b1;
        i_rdata = '0; i_rresp = '0; i_bresp = '0;

        vt[0]  = mk(0,0,32'h12345678,0,0,0, 0,0, 1,32'h12345678,0,0, 0,0,0,0,0);
        vt[1]  = mk(0,1,32'h80000002,32'hDEADBEEF,4'hF,0, 0,0, 0,0,1,6, 0,0,0,0,0);
        vt[2]  = mk(0,1,32'h80000001,32'h000000AB,4'h1,0, 0,0, 0,0,0,0, 1,32'h80000001,32'h0000AB00,4'b0010,0);
        vt[3]  = mk(1,0,32'h80000001,0,0,3'b000, 32'h0000AB00,0, 1,32'hFFFFFFAB,0,0, 0,0,0,0,0);
        vt[4]  = mk(1,0,32'h80000001,0,0,3'b100, 32'h0000AB00,0, 1,32'h000000AB,0,0, 0,0,0,0,0);
        vt[5]  = mk(1,0,32'h80000002,0,0,3'b001, 32'h80010000,0, 1,32'hFFFF8001,0,0, 0,0,0,0,0);
        vt[6]  = mk(1,0,32'h80000002,0,0,3'b101, 32'h80010000,0, 1,32'h00008001,0,0, 0,0,0,0,0);
        vt[7]  = mk(1,0,32'h80000004,0,0,3'b010, 32'hCAFEF00D,0, 1,32'hCAFEF00D,0,0, 0,0,0,0,0);
        vt[8]  = mk(1,0,32'h80000003,0,0,3'b001, 0,0, 0,0,1,4, 0,0,0,0,0);
        vt[9]  = mk(1,0,32'h80000001,0,0,3'b010, 0,0, 0,0,1,4, 0,0,0,0,0);
        vt[10] = mk(1,0,32'h80000000,0,0,3'b010, 32'h11111111,2, 0,0,1,5, 0,0,0,0,0);
        vt[11] = mk(0,1,32'h80000002,32'h00001234,4'h3,0, 0,0, 0,0,0,0, 1,32'h80000002,32'h12340000,4'b1100,1);
        vt[12] = mk(0,1,32'h80000008,32'h11223344,4'hF,0, 0,0, 0,0,0,0, 1,32'h80000008,32'h11223344,4'b1111,2);
        vt[13] = mk(0,1,32'h80000001,32'h00005678,4'h3,0, 0,0, 0,0,1,6, 0,0,0,0,0);
        vt[14] = mk(1,0,32'h80000003,0,0,3'b000, 32'h7F000000,0, 1,32'h0000007F,0,0, 0,0,0,0,0);
        vt[15] = mk(1,0,32'h80000002,0,0,3'b000, 32'h00800000,0, 1,32'hFFFFFF80,0,0, 0,0,0,0,0);

        repeat (3) @(posedge i_clock);
        #1 i_reset_n = 1'b1;
        @(negedge i_clock);
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_arvalid", {63'd0, o_arvalid}, 64'd0);
        chk("rst_awvalid", {63'd0, o_awvalid}, 64'd0);
        chk("rst_wvalid", {63'd0, o_wvalid}, 64'd0);
        chk("rst_exc", {63'd0, o_exception}, 64'd0);
        chk("rst_store_err", {63'd0, o_store_err}, 64'd0);
        chk("rst_result", {32'd0, o_result}, 64'd0);
        chk("rst_sb_empty", {63'd0, o_sb_empty}, 64'd1);
        @(posedge i_clock); #1;

        for (int i = 0; i < 16; i++) begin
            i_rdata = vt[i].rdata; i_rresp = vt[i].rresp;
            push_exp(vt[i].res, vt[i].chk_res, vt[i].exc, vt[i].mc, 64'hA5A5_0000_0000_0000 | 64'(i));
            if (vt[i].wr) push_w(vt[i].wa, vt[i].wd, vt[i].ws, vt[i].wsz);
            send(vt[i].ren, vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].mask, vt[i].rt,
                 64'hA5A5_0000_0000_0000 | 64'(i));
            wait_idle(0);
        end
        i_rresp = 2'b00;

        // Fill the buffer with the write address channel stalled.
        i_awready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_exp(0, 0, 0, 0, 64'h100 + 64'(k));
            push_w(32'h80000100 + 32'(4*k), 32'(k + 1), 4'hF, 3'd2);
            send(0, 1, 32'h80000100 + 32'(4*k), 32'(k + 1), 4'hF, 3'b010, 64'h100 + 64'(k));
            wait_idle(1);
        end
        push_exp(0, 0, 0, 0, 64'h104);
        push_w(32'h80000110, 32'd5, 4'hF, 3'd2);
        i_valid = 1'b1; i_wen = 1'b1; i_ren = 1'b0; i_addr = 32'h80000110; i_wdata = 32'd5;
        i_wmask = 4'hF; i_side = 64'h104;
        repeat (3) begin
            @(negedge i_clock);
            chk("full_ready_low", {63'd0, o_ready}, 64'd0);
        end
        @(posedge i_clock); #1 i_awready = 1'b1;
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge i_clock);
            got = o_ready;
        end
        chk("full_accept", {63'd0, got}, 64'd1);
        chk("push_pop_same_cycle", {63'd0, i_bvalid}, 64'd1);
        @(posedge i_clock); #1 i_valid = 1'b0; i_wen = 1'b0;
        wait_idle(0);

        // Load queued behind two buffered stores.
        i_awready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_exp(0, 0, 0, 0, 64'h200 + 64'(k));
            push_w(32'h80000200 + 32'(4*k), 32'hA0 + 32'(k), 4'hF, 3'd2);
            send(0, 1, 32'h80000200 + 32'(4*k), 32'hA0 + 32'(k), 4'hF, 3'b010, 64'h200 + 64'(k));
            wait_idle(1);
        end
        i_rdata = 32'h55AA55AA;
        push_exp(32'h55AA55AA, 1, 0, 0, 64'h202);
        send(1, 0, 32'h80000200, 0, 0, 3'b010, 64'h202);
        seen = 1'b0;
        repeat (6) begin
            @(negedge i_clock);
            seen = seen | o_arvalid;
        end
        chk("ar_blocked", {63'd0, seen}, 64'd0);
        chk("sb_not_empty", {63'd0, o_sb_empty}, 64'd0);
        @(posedge i_clock); #1 i_awready = 1'b1;
        wait_idle(0);

        // Store bus error.
        i_bresp = 2'b10;
        push_exp(0, 0, 0, 0, 64'h300);
        push_w(32'h80000300, 32'h0BAD0BAD, 4'hF, 3'd2);
        send(0, 1, 32'h80000300, 32'h0BAD0BAD, 4'hF, 3'b010, 64'h300);
        wait_idle(0);
        i_bresp = 2'b00;
        repeat (2) @(posedge i_clock); #1;

        // Downstream stall in RESP.
        i_ready = 1'b0;
        push_exp(32'h0000BEEF, 1, 0, 0, 64'hFEED_FACE_0000_0001);
        send(0, 0, 32'h0000BEEF, 0, 0, 0, 64'hFEED_FACE_0000_0001);
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge i_clock);
            got = o_valid;
        end
        chk("stall_valid_seen", {63'd0, got}, 64'd1);
        repeat (3) @(negedge i_clock);
        @(posedge i_clock); #1 i_ready = 1'b1;
        wait_idle(0);

        // Flush blocks acceptance.
        saved = xfer_cnt;
        i_valid = 1'b1; i_flush = 1'b1; i_addr = 32'h0F0F0F0F;
        repeat (3) @(posedge i_clock);
        #1 i_valid = 1'b0; i_flush = 1'b0;
        wait_idle(0);
        chk("flush_block", 64'(xfer_cnt), 64'(saved));

        // Reset in the middle of a load.
        i_arready = 1'b0;
        send(1, 0, 32'h80000400, 0, 0, 3'b010, 64'h400);
        repeat (3) @(negedge i_clock);
        chk("ar_pending", {63'd0, o_arvalid}, 64'd1);
        @(posedge i_clock); #1 i_reset_n = 1'b0;
        @(negedge i_clock);
        chk("rst_mid_arvalid", {63'd0, o_arvalid}, 64'd0);
        chk("rst_mid_valid", {63'd0, o_valid}, 64'd0);
        @(posedge i_clock); #1 i_reset_n = 1'b1; i_arready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge i_clock);
            seen = seen | o_valid;
        end
        chk("no_resp_after_reset", {63'd0, seen}, 64'd0);

        chk("aw_count", 64'(aw_cnt), 64'(wr_total));
        chk("ar_order_violations", 64'(viol), 64'd0);
        chk("store_err_pulses", 64'(err_rise), 64'd1);
        chk("store_err_cycles", 64'(err_hi), 64'd1);
        chk("resp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("write_q_empty", 64'(wexp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_24110006_lsu_sb.md
YSYX_24110006_LSU_SB -- requirements
Module: ysyx_24110006_lsu_sb

Parameters
REQ-001 SHALL have parameter SB_DEPTH, default 4, number of store-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter SIDE_W, default 64, width of the opaque sideband bundle (rd, wen, csr, pc, ...) carried with each op.

Interface
REQ-003 SHALL use one clock; reset is asynchronous and active-low:
  i_clock  in  1  clock, all state on rising edge
  i_reset_n  in  1  asynchronous active-low reset
  i_valid / o_ready  in/out  1/1  upstream handshake
  i_flush  in  1  discard upstream op this cycle
  i_ren, i_wen  in  1,1  load / store op
  i_addr  in  32  byte address (also non-memory result)
  i_wdata, i_wmask  in  32,4  store data, strobe relative to byte 0
  i_read_t  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
  i_side  in  SIDE_W  sideband, returned unchanged on o_side
  o_valid / i_ready  out/in  1/1  downstream handshake
  o_result  out  32  load data or i_addr
  o_side  out  SIDE_W  registered sideband
  o_exception, o_mcause  out  1,4  fault flag, cause
  o_store_err  out  1  one-cycle pulse on buffered-store bus error
  o_sb_empty  out  1  store buffer empty
  AXI4 master (ar*, r*, aw*, w*, b* as in the core bus): id=0, len=0, burst=0, wlast=1

Function
REQ-004 Accept = i_valid && o_ready && !i_flush; on accept, the op, address, data and sideband SHALL be registered.
REQ-005 o_ready SHALL be 1 only in state IDLE, and SHALL be 0 while a store is presented with the buffer full.
REQ-006 Main FSM states: IDLE, SBWAIT, AR, R, RESP. RESP holds o_valid=1 and all outputs stable until i_ready; then go to IDLE.
REQ-007 Non-memory op: IDLE->RESP; o_result=i_addr; o_valid 1 cycle after accept.
REQ-008 Misaligned access (lh/lhu/sh addr[0]!=0; lw/sw addr[1:0]!=0) SHALL issue no bus traffic; IDLE->RESP with o_exception=1, mcause 4 (load) or 6 (store).
REQ-009 Store: push {addr, lane-shifted data, strobe<<addr[1:0], awsize} into the buffer; IDLE->RESP next cycle; no exception.
REQ-010 Load: IDLE->SBWAIT until o_sb_empty=1 (load never overtakes a store), then AR; arvalid held until arready; then R.
REQ-011 R: on rvalid, data = rdata>>(8*addr[1:0]), sign/zero-extended per read_t; rresp!=0 gives o_exception=1, mcause 5; ->RESP.
REQ-012 arsize/awsize SHALL be 0/1/2 for byte/half/word.
REQ-013 rready and bready SHALL be 1 whenever reset is not asserted.
REQ-014 Drain FSM (independent): when the buffer is non-empty, assert awvalid and wvalid from the head entry; each drops individually on its own ready; pop on bvalid.
REQ-015 bresp!=0 SHALL pulse o_store_err for one cycle; the entry is still popped.
REQ-016 Push and pop in the same cycle SHALL be legal at any occupancy, including full; occupancy is unchanged.
REQ-017 Pointers SHALL wrap modulo SB_DEPTH; full/empty SHALL use a count of log2(SB_DEPTH)+1 bits.
REQ-018 i_flush SHALL block acceptance only; it SHALL NOT cancel an op in progress or buffered stores.

Reset
REQ-019 On i_reset_n=0: FSMs IDLE, buffer empty, o_valid=0, o_ready=1 (after release), arvalid/awvalid/wvalid=0, o_exception=0, o_store_err=0, o_result=0, o_sb_empty=1.
REQ-020 Reset mid-transaction SHALL abandon the transaction with no later output.

Verification
REQ-021 sw 0xDEADBEEF @0x80000002 -> o_valid, exception=1, mcause=6, no awvalid.
REQ-022 sb 0xAB @0x80000001 -> awaddr 0x80000001, wdata 0x0000AB00, wstrb 0010, awsize 0; then lb same address with rdata 0x0000AB00 -> o_result 0xFFFFFFAB.
REQ-023 Four stores with awready=0 (SB_DEPTH=4) -> o_ready=0 on the 5th store; one bvalid -> 5th store accepted; push and pop occur in the same cycle.
REQ-024 Load issued behind two buffered stores -> arvalid not asserted until o_sb_empty=1.
REQ-025 Load with rresp=2 -> exception=1, mcause=5; store with bresp=2 -> one-cycle o_store_err.
REQ-026 i_ready=0 for 3 cycles in RESP -> o_result/o_side stable, with one transfer per op.
